// File: rtl/key_conditioner_if.sv
// Key bundle between the raw DE2 pushbuttons and the conditioned key outputs.
// The master side drives the raw active-low keys; the slave side is the conditioner.
interface key_conditioner_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;

  modport master (
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_repeat
  );

  modport slave (
    input  key_n,
    output key_level,
    output key_press,
    output key_release,
    output key_repeat
  );
endinterface

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per key a two-flop synchroniser, a stable-sample
// debouncer and a press/hold/repeat FSM producing a clean level plus
// one-cycle press, release and auto-repeat pulses. Channels are independent.
module key_conditioner #(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  key_conditioner_if.slave bus
);

  localparam int RPT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int DEB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int RPT_W   = $clog2(RPT_MAX);

  // Counter reaching DEB_LAST on a mismatching sample means this sample is
  // the DEBOUNCE_CYC-th consecutive one, so the level is accepted now.
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RPT_W-1:0] HOLD_LOAD = RPT_W'(HOLD_CYC - 1);
  localparam logic [RPT_W-1:0] REP_LOAD  = RPT_W'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESSED   = 2'd1,
    S_REPEATING = 2'd2
  } state_t;

  logic [N_KEYS-1:0] w_level;
  logic [N_KEYS-1:0] w_press;
  logic [N_KEYS-1:0] w_release;
  logic [N_KEYS-1:0] w_repeat;

  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
      logic             r_sync1;
      logic             r_sync2;
      logic [DEB_W-1:0] r_deb_cnt;
      logic             r_deb_lvl;
      state_t           r_state;
      state_t           w_state_next;
      logic [RPT_W-1:0] r_rpt_cnt;
      logic [RPT_W-1:0] w_rpt_next;
      logic             r_level;
      logic             r_press;
      logic             r_release;
      logic             r_repeat;
      logic             w_press_next;
      logic             w_release_next;
      logic             w_repeat_next;

      // Bring the raw key into clk, inverted so 1 means pressed.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
        end else begin
          r_sync1 <= ~bus.key_n[gi];
          r_sync2 <= r_sync1;
        end
      end

      // Accept a new level only after DEBOUNCE_CYC consecutive differing samples.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_deb_cnt <= '0;
          r_deb_lvl <= 1'b0;
        end else if (r_sync2 == r_deb_lvl) begin
          r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          r_deb_lvl <= ~r_deb_lvl;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end

      // Next-state and pulse decode; a release always beats a repeat expiry.
      always_comb begin
        w_state_next   = r_state;
        w_rpt_next     = r_rpt_cnt;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        w_repeat_next  = 1'b0;
        case (r_state)
          S_IDLE: begin
            if (r_deb_lvl) begin
              w_state_next  = S_PRESSED;
              w_press_next  = 1'b1;
              w_repeat_next = 1'b1;
              w_rpt_next    = HOLD_LOAD;
            end
          end
          S_PRESSED, S_REPEATING: begin
            if (!r_deb_lvl) begin
              w_state_next   = S_IDLE;
              w_release_next = 1'b1;
              w_rpt_next     = '0;
            end else if (r_rpt_cnt == '0) begin
              w_state_next  = S_REPEATING;
              w_repeat_next = 1'b1;
              w_rpt_next    = REP_LOAD;
            end else begin
              w_rpt_next = r_rpt_cnt - 1'b1;
            end
          end
          default: begin
            w_state_next = S_IDLE;
            w_rpt_next   = '0;
          end
        endcase
      end

      // State, repeat counter and registered outputs.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_state   <= S_IDLE;
          r_rpt_cnt <= '0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
          r_repeat  <= 1'b0;
        end else begin
          r_state   <= w_state_next;
          r_rpt_cnt <= w_rpt_next;
          r_level   <= (w_state_next != S_IDLE);
          r_press   <= w_press_next;
          r_release <= w_release_next;
          r_repeat  <= w_repeat_next;
        end
      end

      assign w_level[gi]   = r_level;
      assign w_press[gi]   = r_press;
      assign w_release[gi] = r_release;
      assign w_repeat[gi]  = r_repeat;
    end
  endgenerate

  assign bus.key_level   = w_level;
  assign bus.key_press   = w_press;
  assign bus.key_release = w_release;
  assign bus.key_repeat  = w_repeat;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/hold/repeat periods.
module tb_key_conditioner;
  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int NV   = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_conditioner_if #(.N_KEYS(N)) kif ();

  key_conditioner #(
    .N_KEYS(N), .DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(kif)
  );

  typedef struct {
    logic [3:0] key_n;
    int         steps;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
  } vec_t;

  typedef struct {
    int c;
    int k;
    int kind;  // 0 press, 1 release, 2 repeat
  } ev_t;

  vec_t vt[NV];
  ev_t  ev_q[$];
  int   cyc = 0;
  int   excl_viol = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log, stamped with the index of the edge that produced it.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (kif.key_press[k] === 1'b1)   ev_q.push_back('{cyc, k, 0});
      if (kif.key_release[k] === 1'b1) ev_q.push_back('{cyc, k, 1});
      if (kif.key_repeat[k] === 1'b1)  ev_q.push_back('{cyc, k, 2});
      if (kif.key_press[k] === 1'b1 && kif.key_release[k] === 1'b1) excl_viol = excl_viol + 1;
    end
  end

  function automatic vec_t mk(logic [3:0] kn, int st, logic [3:0] l, logic [3:0] p,
                              logic [3:0] r, logic [3:0] q);
    vec_t v;
    v.key_n = kn; v.steps = st; v.lvl = l; v.prs = p; v.rel = r; v.rpt = q;
    return v;
  endfunction

  function automatic int cnt_ev(int k, int kind, int from, int to);
    int n = 0;
    foreach (ev_q[i])
      if (ev_q[i].k == k && ev_q[i].kind == kind && ev_q[i].c >= from && ev_q[i].c <= to)
        n++;
    return n;
  endfunction

  function automatic int cnt_key(int k, int from, int to);
    return cnt_ev(k, 0, from, to) + cnt_ev(k, 1, from, to) + cnt_ev(k, 2, from, to);
  endfunction

  function automatic int has_ev(int k, int kind, int c);
    return (cnt_ev(k, kind, c, c) > 0) ? 1 : 0;
  endfunction

  function automatic int outs();
    return {16'h0, kif.key_level, kif.key_press, kif.key_release, kif.key_repeat};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0, p, r;
    int rpt_off[6];
    rpt_off = '{0, 20, 28, 36, 44, 52};

    // Clean press/release on key0, then all four together with staggered release.
    vt[0]  = mk(4'b1111, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    vt[1]  = mk(4'b1110, 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    vt[2]  = mk(4'b1110, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    vt[3]  = mk(4'b1110, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    vt[4]  = mk(4'b1111, 6, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    vt[5]  = mk(4'b1111, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    vt[6]  = mk(4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    vt[7]  = mk(4'b0000, 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    vt[8]  = mk(4'b0000, 1, 4'b1111, 4'b1111, 4'b0000, 4'b1111);
    vt[9]  = mk(4'b0001, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    vt[10] = mk(4'b0011, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    vt[11] = mk(4'b0111, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    vt[12] = mk(4'b1111, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    vt[13] = mk(4'b1111, 2, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    vt[14] = mk(4'b1111, 1, 4'b1110, 4'b0000, 4'b0001, 4'b0000);
    vt[15] = mk(4'b1111, 1, 4'b1100, 4'b0000, 4'b0010, 4'b0000);
    vt[16] = mk(4'b1111, 1, 4'b1000, 4'b0000, 4'b0100, 4'b0000);
    vt[17] = mk(4'b1111, 1, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    vt[18] = mk(4'b1111, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    kif.key_n = 4'b1111;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      kif.key_n = vt[i].key_n;
      repeat (vt[i].steps) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs(),
            {16'h0, vt[i].lvl, vt[i].prs, vt[i].rel, vt[i].rpt});
      $display("vec%0d key_n=%b out=%04h", i, vt[i].key_n, outs());
    end

    // Bounce on key1: runs of 3 samples never reach the 4-sample threshold.
    s0 = cyc;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      kif.key_n[1] = (((i / 3) % 2) == 1);
    end
    @(negedge clk);
    kif.key_n[1] = 1'b0;
    e0 = cyc + 1;
    repeat (12) @(posedge clk);
    #1;
    check("bounce_quiet", cnt_key(1, s0, e0 + 5), 0);
    check("bounce_press_time", has_ev(1, 0, e0 + 6), 1);
    check("bounce_press_once", cnt_ev(1, 0, s0, cyc), 1);
    check("bounce_isolation", cnt_key(0, s0, cyc) + cnt_key(2, s0, cyc) + cnt_key(3, s0, cyc), 0);
    $display("bounce: stable low from edge %0d, press expected at %0d", e0, e0 + 6);
    @(negedge clk);
    kif.key_n[1] = 1'b1;
    repeat (10) @(posedge clk);

    // Auto-repeat on key2; the accepted release lands on the P+60 expiry.
    @(negedge clk);
    kif.key_n[2] = 1'b0;
    e0 = cyc + 1;
    p = e0 + 6;
    repeat (60) @(posedge clk);
    @(negedge clk);
    kif.key_n[2] = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("rpt_press", has_ev(2, 0, p), 1);
    for (int j = 0; j < 6; j++)
      check($sformatf("rpt_pulse_P+%0d", rpt_off[j]), has_ev(2, 2, p + rpt_off[j]), 1);
    check("rpt_total", cnt_ev(2, 2, p, p + 70), 6);
    check("rpt_release_time", has_ev(2, 1, p + 60), 1);
    check("rpt_none_at_release", has_ev(2, 2, p + 60), 0);
    $display("auto-repeat: press at %0d, %0d repeats", p, cnt_ev(2, 2, p, p + 70));

    // Release/repeat collision on key0 at P+20.
    @(negedge clk);
    kif.key_n[0] = 1'b0;
    e0 = cyc + 1;
    p = e0 + 6;
    repeat (20) @(posedge clk);
    @(negedge clk);
    kif.key_n[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("coll_release", has_ev(0, 1, p + 20), 1);
    check("coll_no_repeat", has_ev(0, 2, p + 20), 0);
    check("coll_repeat_count", cnt_ev(0, 2, p, p + 25), 1);
    check("coll_level", int'(kif.key_level[0]), 0);
    $display("collision: press at %0d, release at %0d", p, p + 20);
    @(negedge clk);
    kif.key_n[0] = 1'b0;
    e0 = cyc + 1;
    repeat (8) @(posedge clk);
    #1;
    check("coll_repress", has_ev(0, 0, e0 + 6), 1);
    @(negedge clk);
    kif.key_n[0] = 1'b1;
    repeat (10) @(posedge clk);

    // Reset while key3 is in the repeating phase.
    @(negedge clk);
    kif.key_n[3] = 1'b0;
    e0 = cyc + 1;
    repeat (31) @(posedge clk);
    #1;
    check("rst_pre_level", int'(kif.key_level[3]), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    r = cyc;
    check("rst_mid_outputs", outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_early_press", cnt_ev(3, 0, r, r + 6), 0);
    check("rst_repress_time", has_ev(3, 0, r + 7), 1);
    $display("reset: asserted at edge %0d, re-press expected at %0d", r, r + 7);
    @(negedge clk);
    kif.key_n[3] = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    check("press_release_exclusive", excl_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
